imem_loader: RTL

Write-side front end for the instruction memory of the single-cycle MIPS core. It accepts a program image as a byte stream from a host over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes them to sequential word addresses starting at 0 and holds the core in reset-like stall (`cpu_hold`) until a complete image has been written. It is the producer for the word-addressed instruction store that the core's PC reads, where PC advances by 1 per instruction.

---
 rtl/imem_loader_if.sv | 21 ++
 rtl/imem_loader.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write bus of the imem loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 8
) ();
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a big-endian program image from a byte stream into instruction memory,
// holding the core stalled until done. Optional trailing checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  imem_loader_if.slave bus,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned LEN_W = 16;
  localparam logic [LEN_W:0] MAX_WORDS = (LEN_W+1)'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_FINISH,
    S_DONE,
    S_ERR
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_POST_DATA = S_CSUM;
`else
  localparam state_t S_POST_DATA = S_FINISH;
`endif

  state_t            state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [LEN_W-1:0]  words_left_q, words_left_d;
  logic [LEN_W-1:0]  len_c;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              xfer_c;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [31:0]       mem_wdata_d;
  logic              in_ready_d, cpu_hold_d, busy_d, done_d, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    len_hi_d     = len_hi_q;
    words_left_d = words_left_q;
    lane_d       = lane_q;
    word_d       = word_q;
    addr_d       = addr_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = bus.mem_addr;
    mem_wdata_d  = bus.mem_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    xfer_c       = bus.in_valid && bus.in_ready;
    len_c        = {len_hi_q, bus.in_data};

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_HI;
          addr_d  = '0;
          lane_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_LEN_HI: begin
        if (xfer_c) begin
          len_hi_d = bus.in_data;
          state_d  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer_c) begin
          words_left_d = len_c;
          if (len_c == '0)                 state_d = S_POST_DATA;
          else if ({1'b0, len_c} > MAX_WORDS) state_d = S_ERR;
          else                             state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer_c) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ bus.in_data;
`endif
          lane_d = 2'(lane_q + 2'd1);
          case (lane_q)
            2'd0: word_d[23:16] = bus.in_data;
            2'd1: word_d[15:8]  = bus.in_data;
            2'd2: word_d[7:0]   = bus.in_data;
            default: begin
              mem_we_d     = 1'b1;
              mem_addr_d   = addr_q;
              mem_wdata_d  = {word_q, bus.in_data};
              addr_d       = ADDR_W'(addr_q + 1'b1);
              words_left_d = LEN_W'(words_left_q - 1'b1);
              if (words_left_q == LEN_W'(1)) state_d = S_POST_DATA;
            end
          endcase
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer_c) state_d = (bus.in_data == csum_q) ? S_FINISH : S_ERR;
      end
`endif
      S_FINISH: state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase

    // Status outputs are registered copies of the decode of the next state
    in_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) || (state_d == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                 || (state_d == S_CSUM)
`endif
                 ;
    busy_d     = in_ready_d || (state_d == S_FINISH);
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERR);
    cpu_hold_d = (state_d != S_DONE);
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      len_hi_q      <= '0;
      words_left_q  <= '0;
      lane_q        <= '0;
      word_q        <= '0;
      addr_q        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q        <= '0;
`endif
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_hold      <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_hi_q      <= len_hi_d;
      words_left_q  <= words_left_d;
      lane_q        <= lane_d;
      word_q        <= word_d;
      addr_q        <= addr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
      bus.in_ready  <= in_ready_d;
      bus.mem_we    <= mem_we_d;
      bus.mem_addr  <= mem_addr_d;
      bus.mem_wdata <= mem_wdata_d;
      cpu_hold      <= cpu_hold_d;
      busy          <= busy_d;
      done          <= done_d;
      error         <= error_d;
    end
  end

endmodule
